bcd_bin_sequencer: RTL

Multi-cycle controller that converts a packed BCD word into binary by sequencing a single multiply-by-ten-and-add step over one digit per clock, most significant digit first. It replaces a wide parallel digit-weighting adder with one narrow accumulator plus an FSM, and exposes a start/busy/done handshake. It sits between the BCD keypad/display registers and the binary arithmetic datapath.

---
 rtl/bcd_bin_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/bcd_bin_sequencer.sv
// Serial BCD-to-binary converter, one digit per clock, most significant digit first; BCD_INVALID_CHECK_EN enables invalid-digit error.
// Latency: done visible NDIGITS edges after the accepting edge; start is ignored while busy (nothing queued).
module bcd_bin_sequencer #(
   parameter int NDIGITS = 4,
   parameter int OUT_W   = 14
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [4*NDIGITS-1:0]   bcd_in,
   output logic                   busy,
   output logic                   done,
   output logic [OUT_W-1:0]       bin_out,
   output logic                   error
);

   localparam int SW = 4 * NDIGITS;
   localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t            state, state_nx;
   logic              busy_nx, done_nx;
   logic              accept, last;
   logic [SW-1:0]     sr;
   logic [OUT_W-1:0]  acc;
   logic [CW-1:0]     cnt;
   logic [3:0]        digit;
   logic [OUT_W-1:0]  step;
   logic              err_step;

   assign digit  = sr[SW-1 -: 4];
   assign step   = acc * OUT_W'(10) + OUT_W'(digit);
   assign accept = (state == IDLE) && start;
   assign last   = (state == CONV) && (cnt == CW'(NDIGITS - 1));

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy_nx  = busy;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = CONV;
               busy_nx  = 1'b1;
            end
         end
         CONV: begin
            if (last) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         sr      <= '0;
         acc     <= '0;
         cnt     <= '0;
         bin_out <= '0;
      end else begin
         busy <= busy_nx;
         done <= done_nx;
         if (accept) begin
            sr  <= bcd_in;
            acc <= '0;
            cnt <= '0;
         end else if (state == CONV) begin
            sr  <= sr << 4;
            acc <= step;
            cnt <= cnt + CW'(1);
         end
         // an invalid conversion reports zero rather than a meaningless weighted sum
         if (last) bin_out <= err_step ? '0 : step;
      end
   end

`ifdef BCD_INVALID_CHECK_EN
   logic err_acc;

   assign err_step = err_acc | (digit > 4'd9);

   always_ff @(posedge clock) begin
      if (reset) begin
         err_acc <= 1'b0;
         error   <= 1'b0;
      end else begin
         if (accept)              err_acc <= 1'b0;
         else if (state == CONV)  err_acc <= err_step;
         if (last)                error   <= err_step;
      end
   end
`else
   assign err_step = 1'b0;
   assign error    = 1'b0;
`endif

endmodule
